// File: rtl/apb_pkg.sv
// Shared widths, FSM state type and address helper for the APB completer memory.
package apb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Word index of a byte address; the two byte-offset bits are dropped.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] paddr);
        return IDX_W'(paddr >> 2);
    endfunction

endpackage

// File: rtl/apb_completer_regfile.sv
// Byte-strobed word storage: one write port, one combinational read port.
module apb_completer_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Guard for non-power-of-two depths; in-range reads are a plain array lookup.
    assign o_rdata_c = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/apb_completer_mem.sv
// APB4 completer: wait-state insertion, range-checked byte-strobed memory, registered responses.
module apb_completer_mem
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [STRB_W-1:0] PSTRB,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 5;

    apb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic              r_err;
    logic              r_pready;
    logic [DATA_W-1:0] r_prdata;
    logic              r_pslverr;

    logic [IDX_W-1:0]  w_setup_idx;
    logic              w_setup_err;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_cnt_hit;
    logic              w_unused;

    assign w_setup_idx = word_index(PADDR);
    assign w_setup_err = 32'(w_setup_idx) >= DEPTH;
    // In IDLE the read port looks at the live address so a zero-wait read can register at setup.
    assign w_rd_idx    = (r_state == IDLE) ? w_setup_idx : r_idx;
    assign w_we        = (r_state == ACCESS) && PSEL && PENABLE && r_pready && r_write && !r_err;
    assign w_cnt_nxt   = r_cnt + CNT_W'(1);
    assign w_cnt_hit   = (w_cnt_nxt == CNT_W'(WAIT_CYCLES));
    assign w_unused    = &{1'b0, w_rd_idx[IDX_W-1:MEM_AW]};

    apb_completer_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_we      (w_we),
        .i_waddr   (r_idx[MEM_AW-1:0]),
        .i_wstrb   (PSTRB),
        .i_wdata   (PWDATA),
        .i_raddr   (w_rd_idx[MEM_AW-1:0]),
        .o_rdata_c (w_rdata)
    );

    // Transfer FSM with wait counter and registered response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    if (PSEL && !PENABLE) begin
                        r_state <= ACCESS;
                        r_cnt   <= '0;
                        r_idx   <= w_setup_idx;
                        r_write <= PWRITE;
                        r_err   <= w_setup_err;
                        if (WAIT_CYCLES == 0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_setup_err;
                            r_prdata  <= (!PWRITE && !w_setup_err) ? w_rdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSEL || r_pready) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_pready  <= 1'b0;
                        r_prdata  <= '0;
                        r_pslverr <= 1'b0;
                    end else if (PENABLE) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_hit) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (!r_write && !r_err) ? w_rdata : '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign PREADY  = r_pready;
    assign PRDATA  = r_prdata;
    assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances (1, 0 and 3 wait states) on a shared bus.
module tb_apb_completer_mem;

    localparam int NDUT  = 3;
    localparam int DEPTH = 32;
    localparam int LIMIT = 40;

    int unsigned waits [NDUT] = '{1, 0, 3};

    logic            PCLK;
    logic            PRESETn;
    logic [NDUT-1:0] psel;
    logic            penable;
    logic            pwrite;
    logic [7:0]      paddr;
    logic [31:0]     pwdata;
    logic [3:0]      pstrb;
    logic [NDUT-1:0] pready;
    logic [31:0]     prdata [NDUT];
    logic [NDUT-1:0] pslverr;

    int checks = 0;
    int errors = 0;
    int pulses [NDUT] = '{0, 0, 0};
    logic [31:0] mdl [NDUT][DEPTH];

    apb_completer_mem #(.DEPTH(32), .WAIT_CYCLES(1)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb_completer_mem #(.DEPTH(32), .WAIT_CYCLES(0)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    apb_completer_mem #(.DEPTH(32), .WAIT_CYCLES(3)) u_dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Count every sampled cycle with PREADY high, per instance.
    always @(negedge PCLK) begin
        for (int i = 0; i < NDUT; i++) begin
            if (pready[i] === 1'b1) pulses[i]++;
        end
    end

    // Reference memory model.
    function automatic bit addr_err(input logic [7:0] a);
        return int'(a >> 2) >= DEPTH;
    endfunction

    function automatic void mdl_clear();
        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < DEPTH; w++)
                mdl[d][w] = 32'h0;
    endfunction

    function automatic void mdl_write(input int d, input logic [7:0] a, input logic [31:0] data,
                                      input logic [3:0] strb);
        if (!addr_err(a)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][int'(a >> 2)][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [7:0] a);
        return addr_err(a) ? 32'h0 : mdl[d][int'(a >> 2)];
    endfunction

    task automatic bus_idle();
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    // Drives one transfer starting just after a rising edge; returns just after its closing edge.
    task automatic apb_xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output int cyc);
        int n;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = strb;
        cyc     = 1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        cyc     = 2;
        n       = 0;
        @(negedge PCLK);
        while (pready[d] !== 1'b1 && n < LIMIT) begin
            @(posedge PCLK); #1;
            cyc++;
            @(negedge PCLK);
            n++;
        end
        rd  = prdata[d];
        err = pslverr[d];
        if (n >= LIMIT) begin
            checks++; errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%h: PREADY never rose in %0d cycles", d, a, LIMIT);
        end
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          n;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut=%0d: got ready=%b data=%h err=%b, want 0/0/0",
                         d, pready[d], prdata[d], pslverr[d]);
            end
        end
        apb_xfer(0, 1'b1, 8'h00, $urandom | 32'h1, 4'hF, rd, err, cyc);
        // Read 0x00 and hit reset while the response is on the bus.
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        @(posedge PCLK); #1;
        penable = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (pready[0] !== 1'b1 && n < LIMIT) begin @(negedge PCLK); n++; end
        #1 PRESETn = 1'b0;
        #1;
        checks++;
        if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: got ready=%b data=%h err=%b, want 0/0/0",
                     pready[0], prdata[0], pslverr[0]);
        end
        bus_idle();
        mdl_clear();
        @(negedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_after_reset: got data=%h err=%b, want 00000000/0", rd, err);
        end
    endtask

    task automatic test_full_strobe();
        logic [31:0] rd;
        logic        err;
        int          cyc;
        apb_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        mdl_write(0, 8'h04, 32'hDEADBEEF, 4'hF);
        checks++;
        if (cyc !== 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL full_write: got cycles=%0d err=%b, want 3/0", cyc, err);
        end
        apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (cyc !== 3 || rd !== 32'hDEADBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL full_read: got cycles=%0d data=%h err=%b, want 3/deadbeef/0", cyc, rd, err);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd;
        logic        err;
        int          cyc;
        apb_xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd, err, cyc);
        apb_xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, rd, err, cyc);
        mdl_write(0, 8'h08, 32'h11223344, 4'hF);
        mdl_write(0, 8'h08, 32'hAABBCCDD, 4'b0101);
        apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (rd !== 32'h11BB33DD || err !== 1'b0) begin
            errors++;
            $display("FAIL partial_strobe: got data=%h err=%b, want 11bb33dd/0", rd, err);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic        err;
        int          cyc;
        logic [7:0]  a;
        apb_xfer(0, 1'b1, 8'h80, $urandom, 4'hF, rd, err, cyc);
        checks++;
        if (err !== 1'b1 || cyc !== 3) begin
            errors++;
            $display("FAIL oor_write: got err=%b cycles=%0d, want 1/3", err, cyc);
        end
        a = 8'(8'h80 + $urandom_range(0, 127));
        apb_xfer(0, 1'b1, a, $urandom, 4'hF, rd, err, cyc);
        bus_idle();
        for (int w = 0; w < DEPTH; w++) begin
            apb_xfer(0, 1'b0, 8'(w * 4), 32'h0, 4'h0, rd, err, cyc);
            checks++;
            if (rd !== mdl[0][w] || err !== 1'b0) begin
                errors++;
                $display("FAIL oor_mem_intact word=%0d: got %h err=%b, want %h/0", w, rd, err, mdl[0][w]);
            end
        end
        apb_xfer(0, 1'b0, 8'h80, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (rd !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got data=%h err=%b, want 00000000/1", rd, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d0, d1;
        logic        err;
        int          cyc;
        int          p0;
        logic [7:0]  a0, a1;
        a0 = 8'($urandom_range(0, 31) * 4);
        a1 = 8'($urandom_range(0, 31) * 4);
        d0 = $urandom;
        d1 = $urandom;
        p0 = pulses[1];
        for (int k = 0; k < 4; k++) begin
            logic [7:0]  a;
            logic [31:0] wd;
            a  = (k < 2) ? a0 : a1;
            wd = (k < 2) ? d0 : d1;
            apb_xfer(1, (k % 2) == 0, a, wd, 4'hF, rd, err, cyc);
            if ((k % 2) == 0) begin
                mdl_write(1, a, wd, 4'hF);
            end else begin
                checks++;
                if (rd !== mdl_read(1, a) || err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_read k=%0d: got %h err=%b, want %h/0", k, rd, err, mdl_read(1, a));
                end
            end
            checks++;
            if (cyc !== 2) begin
                errors++;
                $display("FAIL b2b_cycles k=%0d: got %0d, want 2", k, cyc);
            end
        end
        bus_idle();
        @(posedge PCLK); #1;
        checks++;
        if (pulses[1] - p0 !== 4) begin
            errors++;
            $display("FAIL b2b_pready_pulses: got %0d, want 4", pulses[1] - p0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, old;
        logic        err;
        int          cyc;
        old = $urandom;
        apb_xfer(2, 1'b1, 8'h0C, old, 4'hF, rd, err, cyc);
        mdl_write(2, 8'h0C, old, 4'hF);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = ~old; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        bus_idle();
        @(negedge PCLK);
        checks++;
        if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got ready=%b err=%b, want 0/0", pready[2], pslverr[2]);
        end
        @(posedge PCLK); #1;
        apb_xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (rd !== old || err !== 1'b0 || cyc !== 5) begin
            errors++;
            $display("FAIL abort_read: got data=%h err=%b cycles=%0d, want %h/0/5", rd, err, cyc, old);
        end
    endtask

    task automatic test_protocol_violation();
        logic [31:0] rd;
        logic        err;
        int          cyc;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = $urandom; pstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            checks++;
            if (pready[0] !== 1'b0) begin
                errors++;
                $display("FAIL penable_in_idle cyc=%0d: got ready=%b, want 0", k, pready[0]);
            end
        end
        @(posedge PCLK); #1;
        bus_idle();
        @(posedge PCLK); #1;
        apb_xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, cyc);
        bus_idle();
        checks++;
        if (rd !== mdl_read(0, 8'h10) || cyc !== 3) begin
            errors++;
            $display("FAIL after_violation: got data=%h cycles=%0d, want %h/3", rd, cyc, mdl_read(0, 8'h10));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_d;
        logic        err;
        int          cyc, d;
        bit          wr;
        logic [7:0]  a;
        logic [3:0]  strb;
        int          p0 [NDUT];
        int          nx [NDUT];
        for (int i = 0; i < NDUT; i++) begin p0[i] = pulses[i]; nx[i] = 0; end
        for (int it = 0; it < 80; it++) begin
            d    = int'($urandom_range(0, NDUT - 1));
            wr   = 1'($urandom);
            a    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
            wd   = $urandom;
            strb = 4'($urandom);
            exp_d = mdl_read(d, a);
            apb_xfer(d, wr, a, wd, strb, rd, err, cyc);
            nx[d]++;
            checks++;
            if (err !== addr_err(a) || cyc !== int'(waits[d]) + 2 || (!wr && rd !== exp_d)) begin
                errors++;
                $display("FAIL random it=%0d dut=%0d wr=%0d addr=%h: got data=%h err=%b cycles=%0d, want data=%h err=%b cycles=%0d",
                         it, d, wr, a, rd, err, cyc, exp_d, addr_err(a), waits[d] + 2);
            end
            if (wr) mdl_write(d, a, wd, strb);
            if ($urandom_range(0, 1) == 0) begin
                bus_idle();
                @(posedge PCLK); #1;
            end
        end
        bus_idle();
        @(posedge PCLK); #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (pulses[i] - p0[i] !== nx[i]) begin
                errors++;
                $display("FAIL random_pulses dut=%0d: got %0d, want %0d", i, pulses[i] - p0[i], nx[i]);
            end
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        bus_idle();
        paddr  = 8'h0;
        pwdata = 32'h0;
        pstrb  = 4'h0;
        mdl_clear();
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        test_reset();
        test_full_strobe();
        test_partial_strobe();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_protocol_violation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
